// File: rtl/conv_mac_accumulator.sv
// conv_mac_accumulator
// Accumulates a fixed window of COUNT signed products (one convolution kernel
// window) on top of a per-window bias, then emits one saturated WIDTH-bit
// result over a valid/ready handshake.
//
// Ports:
//   clk           clock, rising edge
//   reset         synchronous active-high reset
//   io_in_valid   product beat valid
//   io_in_ready   beat can be accepted this cycle (combinational)
//   io_in_data    signed scaled product
//   io_bias       signed bias, sampled on the first beat of each window
//   io_out_valid  result valid
//   io_out_ready  consumer accepts result
//   io_out_data   saturated window sum
//   io_out_sat    result was clipped
//   io_busy       partial window in progress (combinational)
module conv_mac_accumulator #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 24,
  parameter int unsigned COUNT     = 9,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_data,
  input  logic [WIDTH-1:0] io_bias,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_data,
  output logic             io_out_sat,
  output logic             io_busy
);

  localparam int unsigned EXT_W = ACC_WIDTH - WIDTH;
  localparam int unsigned TOP_W = ACC_WIDTH - WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);
  localparam logic [WIDTH-1:0] SAT_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CNT_W-1:0]     count;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH-1:0] sum;
  logic [TOP_W-1:0]     sum_top;
  logic                 last_beat;
  logic                 in_fire;
  logic                 sum_ovf;
  logic [WIDTH-1:0]     sat_data;

  // Handshake, running sum and saturation
  always_comb begin
    last_beat   = (count == LAST_CNT);
    // Only the final beat needs a free output slot.
    io_in_ready = !last_beat || !io_out_valid || io_out_ready;
    in_fire     = io_in_valid && io_in_ready;
    io_busy     = (count != '0);

    // First beat of a window restarts from the bias instead of acc.
    base = (count == '0) ? {{EXT_W{io_bias[WIDTH-1]}}, io_bias} : acc;
    sum  = base + {{EXT_W{io_in_data[WIDTH-1]}}, io_in_data};

    // Sum fits in WIDTH bits only if all bits from the WIDTH sign bit up agree.
    sum_top  = sum[ACC_WIDTH-1:WIDTH-1];
    sum_ovf  = !((&sum_top) || !(|sum_top));
    sat_data = sum[WIDTH-1:0];
    if (sum_ovf) begin
      sat_data = sum[ACC_WIDTH-1] ? SAT_NEG : SAT_POS;
    end
  end

  // Window counter, accumulator and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      acc          <= '0;
      io_out_valid <= 1'b0;
      io_out_data  <= '0;
      io_out_sat   <= 1'b0;
    end else begin
      if (io_out_valid && io_out_ready) begin
        io_out_valid <= 1'b0;
      end
      if (in_fire) begin
        if (last_beat) begin
          io_out_data  <= sat_data;
          io_out_sat   <= sum_ovf;
          io_out_valid <= 1'b1;
          count        <= '0;
        end else begin
          acc   <= sum;
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_accumulator.sv
module tb_conv_mac_accumulator;

  localparam int unsigned WIDTH     = 16;
  localparam int unsigned ACC_WIDTH = 24;
  localparam int unsigned COUNT     = 9;
  localparam int unsigned CNT_W     = 4;

  logic             clk          = 1'b0;
  logic             reset        = 1'b1;
  logic             io_in_valid  = 1'b0;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_data   = '0;
  logic [WIDTH-1:0] io_bias      = '0;
  logic             io_out_valid;
  logic             io_out_ready = 1'b1;
  logic [WIDTH-1:0] io_out_data;
  logic             io_out_sat;
  logic             io_busy;

  conv_mac_accumulator #(
    .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .COUNT(COUNT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready),
    .io_in_data(io_in_data),
    .io_bias(io_bias),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_data(io_out_data),
    .io_out_sat(io_out_sat),
    .io_busy(io_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Scoreboard: {sat, data} per window, plus the cycle of each consumed result
  logic [WIDTH:0] exp_q[$];
  int             pop_cyc[$];
  int             m_cnt = 0;
  int             m_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model of one accepted beat
  task automatic model_accept(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] b);
    if (m_cnt == 0) m_acc = int'($signed(b));
    m_acc += int'($signed(d));
    m_cnt++;
    if (m_cnt == int'(COUNT)) begin
      if (m_acc > 32767)       exp_q.push_back({1'b1, 16'h7FFF});
      else if (m_acc < -32768) exp_q.push_back({1'b1, 16'h8000});
      else                     exp_q.push_back({1'b0, 16'(m_acc)});
      m_cnt = 0;
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: a transfer happens at the next posedge when valid && ready
  always @(negedge clk) begin
    if (!reset && io_out_valid && io_out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(io_out_valid), 32'd0);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        chk("result", 32'({io_out_sat, io_out_data}), 32'(e));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Drive one beat starting at posedge+1; returns at the following posedge+1
  task automatic send(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] b, output int waited);
    waited = 0;
    io_in_valid = 1'b1;
    io_in_data  = d;
    io_bias     = b;
    @(negedge clk);
    while (!io_in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (io_in_ready) model_accept(d, b);
    else chk("in_ready_timeout", 32'(io_in_ready), 32'd1);
    @(posedge clk);
    #1;
    io_in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(io_out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(io_out_data),  32'd0);
    chk({tag, "_out_sat"},   32'(io_out_sat),   32'd0);
    chk({tag, "_busy"},      32'(io_busy),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int stalls;
    int sent;
    int p;
    int pat[5] = '{1, 0, 1, 1, 0};

    // Reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs("reset");
    chk("reset_in_ready", 32'(io_in_ready), 32'd1);

    // Basic sum: bias 50, nine beats of 100
    io_out_ready = 1'b1;
    for (int i = 0; i < int'(COUNT); i++) begin
      chk("basic_busy", 32'(io_busy), 32'(i != 0));
      chk("basic_no_early_valid", 32'(io_out_valid), 32'd0);
      send(16'd100, 16'd50, w);
    end
    chk("basic_latency_valid", 32'(io_out_valid), 32'd1);
    chk("basic_data", 32'(io_out_data), 32'd950);
    chk("basic_sat", 32'(io_out_sat), 32'd0);
    chk("basic_busy_after", 32'(io_busy), 32'd0);
    idle_cycle();
    chk("basic_valid_single", 32'(io_out_valid), 32'd0);

    // Positive and negative saturation
    for (int i = 0; i < int'(COUNT); i++) send(16'h7000, 16'd0, w);
    chk("sat_pos_data", 32'(io_out_data), 32'h7FFF);
    chk("sat_pos_flag", 32'(io_out_sat), 32'd1);
    for (int i = 0; i < int'(COUNT); i++) send(16'h9000, 16'd0, w);
    chk("sat_neg_data", 32'(io_out_data), 32'h8000);
    chk("sat_neg_flag", 32'(io_out_sat), 32'd1);
    idle_cycle();

    // Backpressure: result 9 pending while window 2 streams
    io_out_ready = 1'b0;
    for (int i = 0; i < int'(COUNT); i++) send(16'd1, 16'd0, w);
    chk("bp_w1_valid", 32'(io_out_valid), 32'd1);
    chk("bp_w1_data", 32'(io_out_data), 32'd9);
    for (int i = 0; i < int'(COUNT) - 1; i++) begin
      send(16'd2, 16'd0, w);
      chk("bp_accept_while_pending", 32'(w), 32'd0);
    end
    io_in_valid = 1'b1;
    io_in_data  = 16'd2;
    io_bias     = 16'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 32'(io_in_ready), 32'd0);
      chk("bp_hold_valid", 32'(io_out_valid), 32'd1);
      chk("bp_hold_data", 32'(io_out_data), 32'd9);
      chk("bp_hold_sat", 32'(io_out_sat), 32'd0);
    end
    @(posedge clk);
    #1 io_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_release", 32'(io_in_ready), 32'd1);
    if (io_in_ready) model_accept(16'd2, 16'd0);
    @(posedge clk);
    #1;
    io_out_ready = 1'b0;
    io_in_valid  = 1'b0;
    chk("bp_w2_valid", 32'(io_out_valid), 32'd1);
    chk("bp_w2_data", 32'(io_out_data), 32'd18);
    idle_cycle();
    io_out_ready = 1'b1;
    idle_cycle();
    chk("bp_drained", 32'(io_out_valid), 32'd0);

    // Gapped input, bias changes after the first beat must be ignored
    sent = 0;
    p = 0;
    while (sent < int'(COUNT)) begin
      if (pat[p % 5] != 0) begin
        send(16'hFFFD, (sent == 0) ? 16'd10 : 16'(1000 + sent), w);
        sent++;
      end else begin
        idle_cycle();
      end
      p++;
    end
    chk("gap_data", 32'(io_out_data), 32'h0000_FFEF);
    chk("gap_sat", 32'(io_out_sat), 32'd0);
    idle_cycle();

    // Reset mid-window discards the partial sum
    for (int i = 0; i < 4; i++) send(16'd5, 16'd3, w);
    chk("midreset_busy_before", 32'(io_busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_cnt = 0;
    exp_q.delete();
    check_reset_outputs("midreset");
    for (int i = 0; i < int'(COUNT); i++) send(16'd1, 16'd0, w);
    chk("midreset_data", 32'(io_out_data), 32'd9);
    idle_cycle();

    // Back-to-back windows at full throughput
    pop_cyc.delete();
    stalls = 0;
    for (int k = 1; k <= 3; k++) begin
      for (int i = 0; i < int'(COUNT); i++) begin
        send(16'(k), 16'd0, w);
        stalls += w;
      end
    end
    chk("b2b_no_stalls", 32'(stalls), 32'd0);
    repeat (2) idle_cycle();
    chk("b2b_result_count", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      chk("b2b_spacing_1", 32'(pop_cyc[1] - pop_cyc[0]), 32'(COUNT));
      chk("b2b_spacing_2", 32'(pop_cyc[2] - pop_cyc[1]), 32'(COUNT));
    end

    // Every predicted result must have come out
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle_cycle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
